bist_engine: RTL and testbench

Parametrised built-in self-test sequencer for scan-inserted circuits in the self-test datapath. It drives test-mode muxing and scan_en, generates pseudo-random stimulus with an LFSR, and compacts circuit responses into a MISR. At the end it compares the signature against a compile-time golden value and reports pass/fail. It sits between the functional inputs, the scan-wrapped circuit under test, and the top-level BIST start/end pins.

---
 rtl/bist_engine.sv | 140 ++++++++++++++
 tb/tb_bist_engine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bist_engine.sv
// Logic BIST sequencer: LFSR stimulus, scan shift/capture scheduling, MISR compaction and golden compare.
// Define BIST_SIG_OUT_EN to expose the live MISR value on sig_out for signature characterisation.
module bist_engine #(
  parameter int                 LFSR_W     = 8,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS  = 8'hB8,
  parameter logic [LFSR_W-1:0]  LFSR_SEED  = 8'h01,
  parameter int                 MISR_W     = 16,
  parameter logic [MISR_W-1:0]  MISR_TAPS  = 16'hB400,
  parameter int                 RESP_W     = 3,
  parameter int                 SCAN_LEN   = 8,
  parameter int                 N_PATTERNS = 64,
  parameter logic [MISR_W-1:0]  GOLDEN     = 16'h0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              bist_start,
  input  logic [RESP_W-1:0] resp_in,
  output logic [LFSR_W-1:0] tpg_out,
  output logic              test_mode,
  output logic              scan_en,
  output logic              running,
  output logic              bist_end,
  output logic              pass_fail,
  output logic [2:0]        dbg_state
`ifdef BIST_SIG_OUT_EN
  ,
  output logic [MISR_W-1:0] sig_out
`endif
);

  localparam int SC_W = $clog2(SCAN_LEN + 1);
  localparam int PC_W = $clog2(N_PATTERNS + 1);
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [MISR_W-1:0] misr_q, misr_d;
  logic [SC_W-1:0]   shift_cnt_q, shift_cnt_d;
  logic [PC_W-1:0]   pat_cnt_q, pat_cnt_d;
  logic              pass_q, pass_d;
  logic              advance;
  logic [MISR_W-1:0] resp_ext;

  assign resp_ext = MISR_W'(resp_in);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_EFF;
      misr_q      <= '0;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    pass_d      = pass_q;
    advance     = 1'b0;
    scan_en     = 1'b0;
    running     = 1'b1;
    bist_end    = 1'b0;

    case (state_q)
      S_IDLE: begin
        running = 1'b0;
        if (bist_start) state_d = S_INIT;
      end
      S_INIT: begin
        lfsr_d      = SEED_EFF;
        misr_d      = '0;
        shift_cnt_d = '0;
        pat_cnt_d   = '0;
        pass_d      = 1'b0;
        state_d     = S_SHIFT;
      end
      S_SHIFT, S_UNLOAD: begin
        scan_en = 1'b1;
        advance = 1'b1;
        if (shift_cnt_q == SC_W'(SCAN_LEN - 1)) begin
          shift_cnt_d = '0;
          state_d     = (state_q == S_SHIFT) ? S_CAPTURE : S_COMPARE;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        advance   = 1'b1;
        pat_cnt_d = pat_cnt_q + 1'b1;
        state_d   = (pat_cnt_q + 1'b1 == PC_W'(N_PATTERNS)) ? S_UNLOAD : S_SHIFT;
      end
      S_COMPARE: begin
        pass_d  = (misr_q == GOLDEN);
        state_d = S_DONE;
      end
      S_DONE: begin
        running  = 1'b0;
        bist_end = 1'b1;
        if (bist_start) state_d = S_INIT;
      end
      default: begin
        running = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Stimulus and compaction step together, so resp_in is sampled on the LFSR's advancing edge.
    if (advance) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
      misr_d = {misr_q[MISR_W-2:0], ^(misr_q & MISR_TAPS)} ^ resp_ext;
    end
  end

  assign tpg_out   = lfsr_q;
  assign test_mode = running;
  assign pass_fail = bist_end & pass_q;
  assign dbg_state = state_q;

`ifdef BIST_SIG_OUT_EN
  assign sig_out = misr_q;
`endif

endmodule

// File: tb/tb_bist_engine.sv
// Self-checking bench for bist_engine: randomized CUT response models against a schedule/signature reference.
module tb_bist_engine;

  localparam int SCAN_LEN = 8;
  localparam int N_PAT    = 64;
  localparam int N_UPD    = N_PAT * (SCAN_LEN + 1) + SCAN_LEN;  // MISR update cycles per run
  localparam int T_DONE   = 2 + N_UPD;                          // edge where bist_end rises (586)
  localparam logic [15:0] GOLDEN = 16'h0000;

  // Clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic        bist_start = 1'b0;
  logic [2:0]  resp_in    = 3'b000;
  logic [7:0]  tpg_out;
  logic        test_mode, scan_en, running, bist_end, pass_fail;
  logic [2:0]  dbg_state;
`ifdef BIST_SIG_OUT_EN
  logic [15:0] sig_out;
`endif

  bist_engine dut (
    .CLK        (CLK),
    .RST        (RST),
    .bist_start (bist_start),
    .resp_in    (resp_in),
    .tpg_out    (tpg_out),
    .test_mode  (test_mode),
    .scan_en    (scan_en),
    .running    (running),
    .bist_end   (bist_end),
    .pass_fail  (pass_fail),
    .dbg_state  (dbg_state)
`ifdef BIST_SIG_OUT_EN
    ,
    .sig_out    (sig_out)
`endif
  );

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];  // {expected pass, expected signature} per launched run

  int         cut_mode = 0;
  logic [2:0] cut_mask = 3'b000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic logic [2:0] cut_resp(input logic [7:0] t);
    case (cut_mode)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return t[2:0] ^ cut_mask;
      default: return t[7:5] ^ {t[0], t[3], t[6]};
    endcase
  endfunction

  function automatic logic [15:0] model_sig();
    logic [7:0]  lf = 8'h01;
    logic [15:0] ms = 16'h0000;
    for (int k = 0; k < N_UPD; k++) begin
      ms = {ms[14:0], ^(ms & 16'hB400)} ^ {13'd0, cut_resp(lf)};
      lf = lfsr_step(lf);
    end
    return ms;
  endfunction

  function automatic logic exp_scan_en(input int e);
    if (e >= 1 && e < 1 + N_PAT * (SCAN_LEN + 1)) return ((e - 1) % (SCAN_LEN + 1)) < SCAN_LEN;
    return (e >= 1 + N_PAT * (SCAN_LEN + 1)) && (e < T_DONE - 1);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_running"},   32'(running),   32'd0);
    check({tag, "_test_mode"}, 32'(test_mode), 32'd0);
    check({tag, "_scan_en"},   32'(scan_en),   32'd0);
    check({tag, "_bist_end"},  32'(bist_end),  32'd0);
    check({tag, "_pass_fail"}, 32'(pass_fail), 32'd0);
  endtask

  // Driver: launch a run, check every cycle; optionally re-pulse start or abort with reset.
  task automatic run_check(input int extra_start_edge, input int abort_edge);
    logic [7:0]  lf;
    logic [15:0] sig;
    logic [16:0] exp;
    logic        exp_pass;
    sig = model_sig();
    exp_q.push_back({sig == GOLDEN, sig});
    exp_pass = 1'b0;
    lf = 8'h01;
    @(negedge CLK);
    bist_start = 1'b1;
    for (int e = 0; e <= T_DONE + 3; e++) begin
      @(posedge CLK);
      @(negedge CLK);
      bist_start = (e + 1 == extra_start_edge);
      if (e >= 2 && e < T_DONE) lf = lfsr_step(lf);
      resp_in = cut_resp(lf);
      if (e == abort_edge) begin
        check("abort_running_pre", 32'(running), 32'd1);
        #1 RST = 1'b1;
        #1 check_all_zero("abort");
        @(negedge CLK);
        RST = 1'b0;
        void'(exp_q.pop_back());
        return;
      end
      if (e == T_DONE) begin
        exp = exp_q.pop_front();
        exp_pass = exp[16];
        check("done_bist_end", 32'(bist_end), 32'd1);
        check("done_pass_fail", 32'(pass_fail), 32'(exp[16]));
`ifdef BIST_SIG_OUT_EN
        check("done_sig_out", 32'(sig_out), 32'(exp[15:0]));
`endif
      end
      check("running",   32'(running),   32'(e < T_DONE));
      check("test_mode", 32'(test_mode), 32'(e < T_DONE));
      check("scan_en",   32'(scan_en),   32'(exp_scan_en(e)));
      check("bist_end",  32'(bist_end),  32'(e >= T_DONE));
      check("pass_fail", 32'(pass_fail), 32'((e >= T_DONE) && exp_pass));
      if (e >= 1) check("tpg_out", 32'(tpg_out), 32'(lf));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held, then released: block must stay idle.
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check_all_zero("idle");
    end
    @(negedge CLK);
    #1 RST = 1'b1;
    #1 check_all_zero("async_reset_idle");
    @(negedge CLK);
    RST = 1'b0;

    // Passing run, then restart from DONE after a 10-cycle hold.
    cut_mode = 0;
    run_check(-1, -1);
    repeat (10) begin
      @(negedge CLK);
      check("hold_bist_end", 32'(bist_end), 32'd1);
      check("hold_running", 32'(running), 32'd0);
      check("hold_pass_fail", 32'(pass_fail), 32'd1);
    end
    run_check(-1, -1);

    // Constant response: signature must mismatch the golden value.
    cut_mode = 1;
    run_check(-1, -1);

    // Random response model with bist_start re-asserted at edge 50.
    cut_mode = 2;
    cut_mask = 3'($urandom_range(0, 7));
    run_check(50, -1);

    // Mid-run reset at edge 100, then an identical uninterrupted run.
    cut_mode = 3;
    run_check(-1, 100);
    repeat (2) begin
      @(negedge CLK);
      check_all_zero("post_abort_idle");
    end
    run_check(-1, -1);

    // Additional randomized runs.
    for (int r = 0; r < 2; r++) begin
      cut_mode = $urandom_range(0, 3);
      cut_mask = 3'($urandom_range(0, 7));
      run_check($urandom_range(20, 500), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
